// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - ALU op encodings, sequencer states and command/response records
// Purpose: shared types for the TinyALU command sequencer.
//   operation_t  : 3-bit ALU operation codes driven on alu_op / reported on rsp_op
//   ST_*         : sequencer FSM state codes
//   cmd_t        : 19-bit queued command {op, a, b}
//   rsp_t        : registered response payload {result, op, timeout}
//   decode_op()  : folds undefined op codes onto NO_OP
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_NOP     = 3'd2;
  localparam logic [2:0] ST_ALU_RST = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam int CMD_W = 19;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  op;
    logic        timeout;
  } rsp_t;

  // 101 and 110 have no ALU meaning; they are executed and reported as NO_OP.
  function automatic logic [2:0] decode_op(input logic [2:0] raw);
    case (raw)
      ADD_OP, AND_OP, XOR_OP, MUL_OP, RST_OP: return raw;
      default:                                return NO_OP;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - in-order command FIFO feeding the sequencer
// Purpose: DEPTH-entry (power of two) first-word-fall-through queue.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties the queue)
//   push, push_data : write strobe and data (ignored when full)
//   pop, head       : read strobe and current head entry (ignored when empty)
//   full, empty     : occupancy flags
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands and sequences them onto the TinyALU pins
// Purpose: buffers commands, issues each to the ALU with a start/done handshake and
//   timeout, and returns one registered response per command.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_a/b/op     : command input handshake and payload
//   alu_start, alu_op, alu_a, alu_b     : ALU pin drive
//   alu_reset_n                         : active-low ALU reset
//   alu_done, alu_result                : ALU completion and result
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_result, rsp_op, rsp_timeout     : response payload
module alu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_reset_n,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic [0:0]  rsp_timeout
);
  import tinyalu_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          up;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  cmd_t          push_cmd;
  cmd_t          head_cmd;
  logic [2:0]    head_op;
  rsp_t          rsp_q;

  assign push_cmd  = {cmd_op, cmd_a, cmd_b};
  // up holds cmd_ready low while reset is asserted and until the first edge after.
  assign cmd_ready = up && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign head_op   = decode_op(head_cmd.op);

  assign rsp_result  = rsp_q.result;
  assign rsp_op      = rsp_q.op;
  assign rsp_timeout = rsp_q.timeout;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      up          <= 1'b0;
      alu_start   <= 1'b0;
      alu_op      <= 3'b000;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_q       <= '0;
    end else begin
      up          <= 1'b1;
      alu_reset_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_op <= head_op;
            alu_a  <= head_cmd.a;
            alu_b  <= head_cmd.b;
            cnt    <= '0;
            case (head_op)
              NO_OP: begin
                state     <= ST_NOP;
                alu_start <= 1'b1;
              end
              RST_OP: begin
                state       <= ST_ALU_RST;
                alu_reset_n <= 1'b0;
              end
              default: begin
                state     <= ST_ISSUE;
                alu_start <= 1'b1;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          // done is tested first so it wins over a simultaneous timeout.
          if (alu_done) begin
            alu_start <= 1'b0;
            rsp_q     <= {alu_result, alu_op, 1'b0};
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            alu_start <= 1'b0;
            rsp_q     <= {16'hFFFF, alu_op, 1'b1};
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_NOP: begin
          alu_start <= 1'b0;
          rsp_q     <= {16'h0000, alu_op, 1'b0};
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_ALU_RST: begin
          // Entry edge plus one counted edge gives two cycles of alu_reset_n low.
          if (cnt == CW'(1)) begin
            rsp_q     <= {16'h0000, alu_op, 1'b0};
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt         <= cnt + 1'b1;
            alu_reset_n <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  import tinyalu_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = 8'h00;
  logic [7:0]  cmd_b = 8'h00;
  logic [2:0]  cmd_op = 3'b000;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic [0:0]  rsp_timeout;

  alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_reset_n(alu_reset_n), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // ALU model: raises done in the done_delay-th consecutive start cycle (0 = never).
  int done_delay = 1;
  int scnt = 0;
  always @(negedge clk) scnt <= alu_start ? scnt + 1 : 0;
  assign alu_done = alu_start && (done_delay != 0) && (scnt == done_delay);

  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction
  assign alu_result = alu_model(alu_op, alu_a, alu_b);

  int viol = 0;
  always @(negedge clk) if (alu_start && !alu_reset_n) viol <= viol + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;
    logic [15:0] res;
    logic [2:0]  rop;
    logic        to;
    int          starts;
    int          rstlow;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int delay, input logic [15:0] res, input logic [2:0] rop,
                              input logic to, input int starts, input int rstlow, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.delay = delay; v.res = res; v.rop = rop;
    v.to = to; v.starts = starts; v.rstlow = rstlow; v.lat = lat;
    return v;
  endfunction

  vec_t vecs[10];

  // Latency counts the accept cycle and the first rsp_valid cycle inclusively.
  task automatic run_vec(input string tag, input vec_t v);
    int  k;
    int  starts;
    int  rl;
    int  pinbad;
    logic seen;
    @(negedge clk);
    done_delay = v.delay;
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0; starts = 0; rl = 0; pinbad = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (alu_start) begin
        starts++;
        if (alu_op !== v.rop || alu_a !== v.a || alu_b !== v.b) pinbad++;
      end
      if (!alu_reset_n) rl++;
      if (rsp_valid) seen = 1'b1;
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_result"},   32'(rsp_result), 32'(v.res));
    check({tag, "_op"},       32'(rsp_op), 32'(v.rop));
    check({tag, "_timeout"},  32'(rsp_timeout), 32'(v.to));
    check({tag, "_starts"},   32'(starts), 32'(v.starts));
    check({tag, "_rstlow"},   32'(rl), 32'(v.rstlow));
    check({tag, "_latency"},  32'(k + 1), 32'(v.lat));
    check({tag, "_pins"},     32'(pinbad), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, {15'd0, rsp_valid, rsp_result}, {15'd0, 1'b1, v.res});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int acc;
    int cyc;
    int k;
    int activity;
    logic rdy;

    vecs[0] = mk(ADD_OP, 8'h0F, 8'h01, 1, 16'h0010, 3'b001, 1'b0, 1, 0, 4);
    vecs[1] = mk(MUL_OP, 8'hFF, 8'hFF, 3, 16'hFE01, 3'b100, 1'b0, 3, 0, 6);
    vecs[2] = mk(AND_OP, 8'hF0, 8'h3C, 2, 16'h0030, 3'b010, 1'b0, 2, 0, 5);
    vecs[3] = mk(XOR_OP, 8'hAA, 8'h0F, 1, 16'h00A5, 3'b011, 1'b0, 1, 0, 4);
    vecs[4] = mk(NO_OP,  8'h12, 8'h34, 1, 16'h0000, 3'b000, 1'b0, 1, 0, 4);
    vecs[5] = mk(3'b101, 8'h56, 8'h78, 1, 16'h0000, 3'b000, 1'b0, 1, 0, 4);
    vecs[6] = mk(RST_OP, 8'h00, 8'h00, 1, 16'h0000, 3'b111, 1'b0, 0, 2, 5);
    vecs[7] = mk(ADD_OP, 8'h80, 8'h80, 8, 16'h0100, 3'b001, 1'b0, 8, 0, 11);
    vecs[8] = mk(ADD_OP, 8'h33, 8'h44, 0, 16'hFFFF, 3'b001, 1'b1, 8, 0, 11);
    vecs[9] = mk(MUL_OP, 8'h10, 8'h10, 2, 16'h0100, 3'b100, 1'b0, 2, 0, 5);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready",   32'(cmd_ready), 32'd0);
    check("rst_alu_start",   32'(alu_start), 32'd0);
    check("rst_alu_op",      32'(alu_op), 32'd0);
    check("rst_alu_a",       32'(alu_a), 32'd0);
    check("rst_alu_b",       32'(alu_b), 32'd0);
    check("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
    check("rst_rsp_valid",   32'(rsp_valid), 32'd0);
    check("rst_rsp_payload", {12'd0, rsp_result, rsp_op, rsp_timeout}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_cmd_ready",   32'(cmd_ready), 32'd1);
    check("rel_alu_reset_n", 32'(alu_reset_n), 32'd1);

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // FIFO fill: first command parks in RESP, four more fill the queue, sixth stalls.
    done_delay = 1;
    rsp_ready = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 6 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      cmd_op = ADD_OP; cmd_a = 8'(acc); cmd_b = 8'h01; cmd_valid = 1'b1;
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    #1 cmd_valid = 1'b0;
    check("fifo_accepted", 32'(acc), 32'd5);
    check("fifo_full_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("fifo_rsp%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("fifo_rsp%0d_result", i), 32'(rsp_result), 32'(i + 1));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
    check("fifo_drained_ready", 32'(cmd_ready), 32'd1);

    // Reset while a mul is mid-issue
    repeat (2) @(negedge clk);
    done_delay = 0;
    cmd_op = MUL_OP; cmd_a = 8'h03; cmd_b = 8'h05; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (!alu_start && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("midrst_started", 32'(alu_start), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_alu_start", 32'(alu_start), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk) reset = 1'b0;
    activity = 0;
    repeat (8) begin
      @(negedge clk);
      if (alu_start || rsp_valid) activity++;
    end
    check("midrst_quiet", 32'(activity), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    run_vec("post_rst", vecs[0]);

    check("start_while_alu_reset", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 8, max cycles start may stay high without done.
REQ-003 clk  input  1  single clock; all flops rise-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at clk edge.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_op  input  3  operation_t (no_op 000, add 001, and 010, xor 011, mul 100, rst 111; others = no_op).
REQ-009 alu_start, alu_op[2:0], alu_a[7:0], alu_b[7:0]  output  ALU pin drive.
REQ-010 alu_reset_n  output  1  active-low reset to ALU.
REQ-011 alu_done  input  1; alu_result  input  16  ALU completion and result.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_result[15:0], rsp_op[2:0], rsp_timeout[0:0]  output  response payload.

Function
REQ-014 Commands SHALL be buffered in an in-order FIFO; cmd_ready = FIFO not full; simultaneous push and pop when full SHALL NOT be accepted (ready low).
REQ-015 FSM states SHALL be IDLE, ISSUE, NOP, ALU_RST, RESP.
REQ-016 IDLE: FIFO non-empty -> pop head and go to ISSUE (add/and/xor/mul), NOP (no_op/undefined), or ALU_RST (rst) on the next edge.
REQ-017 ISSUE: alu_start=1, alu_op/a/b held stable from popped command until done or timeout.
REQ-018 ISSUE: alu_done=1 -> capture alu_result, rsp_timeout=0, drop alu_start next cycle, go RESP.
REQ-019 ISSUE: cycle counter reaching TIMEOUT without done -> rsp_result=16'hFFFF, rsp_timeout=1, go RESP.
REQ-020 done arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-021 NOP: alu_start=1 with alu_op=000 for exactly one cycle; then RESP with rsp_result=0, rsp_timeout=0.
REQ-022 ALU_RST: alu_reset_n=0 for exactly 2 cycles, alu_start=0; then RESP with rsp_result=0, rsp_timeout=0.
REQ-023 RESP: rsp_valid=1, payload stable until rsp_valid && rsp_ready; then IDLE (no back-to-back bypass; min 1 idle cycle between commands).
REQ-024 alu_done outside ISSUE SHALL be ignored.
REQ-025 alu_start SHALL never be high while alu_reset_n=0.
REQ-026 Latency cmd accept -> rsp_valid on empty FIFO, ALU done after N start cycles: N+3 cycles.

Reset
REQ-027 reset SHALL asynchronously clear FIFO (empty), state=IDLE, counter=0.
REQ-028 Reset values: cmd_ready=0 during reset and 1 the cycle after release; alu_start=0, alu_op=0, alu_a=0, alu_b=0, alu_reset_n=0 while reset asserted then 1; rsp_valid=0, rsp_result=0, rsp_op=0, rsp_timeout=0.
REQ-029 Reset mid-ISSUE or mid-RESP SHALL drop the command and its response with no further ALU activity.

Structure
REQ-030 operation_t enum and op encodings SHALL come from tinyalu_pkg; sequencer state enum and response struct SHALL be added there.
REQ-031 Command FIFO SHALL be one sub-module, alu_cmd_fifo (parameterised depth, width 19).
REQ-032 The FSM, timeout counter and response register SHALL live in alu_op_sequencer.

Verification
REQ-033 add A=8'h0F B=8'h01, ALU done after 1 start cycle -> rsp_result=16'h0010, rsp_op=001, rsp_timeout=0.
REQ-034 mul A=8'hFF B=8'hFF, done after 3 cycles -> rsp_result=16'hFE01, alu_start high exactly 3 cycles.
REQ-035 Push 5 commands with rsp_ready=0, FIFO_DEPTH=4 -> cmd_ready low after 4th accepted (one held in FSM frees slot: 5th accepted, 6th stalls); responses in push order.
REQ-036 add with alu_done held 0 -> rsp_timeout=1, rsp_result=16'hFFFF after TIMEOUT=8 start cycles.
REQ-037 rst_op -> alu_reset_n low exactly 2 cycles, alu_start low, rsp_op=111, rsp_result=0.
REQ-038 reset asserted mid-mul (start high) -> alu_start=0 and rsp_valid=0 immediately, FIFO empty after release.
